// File: rtl/sonic_vc_rx_fifo_p0_pkt_fifo.sv
// Receive-side packet FIFO: absorbs an unstallable word stream and exposes only
// complete packets on a show-ahead ready/valid port; bad packets are dropped whole.
module sonic_vc_rx_fifo_p0_pkt_fifo #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 133,
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [ADDR_WIDTH:0]       fill_level,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    output logic                      overflow
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W = DROP_CNT_WIDTH + 1;
    localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StPkt, StDrop} state_e;

    state_e                    state_q, state_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          cm_ptr_q, cm_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
    logic [ADDR_WIDTH:0]       fill_level_q, fill_level_d;
    logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;
    logic                      overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_waddr;

    logic                      in_sop, in_eop, full, start_pkt, xfer;
    logic [PTR_W-1:0]          base_ptr, used_base;
    logic [1:0]                drop_inc;
    logic [CNT_W-1:0]          drop_sum;

    assign in_sop = in_data[128];
    assign in_eop = in_data[129];
    assign full   = (wr_ptr_q - rd_ptr_q) == FULL_LVL;

    // Write side: speculative writes at wr_ptr, published by moving cm_ptr on eop.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr_q[ADDR_WIDTH-1:0];
        drop_inc   = 2'd0;
        overflow_d = 1'b0;
        base_ptr   = wr_ptr_q;
        start_pkt  = 1'b0;
        used_base  = '0;
        if (in_valid) begin
            case (state_q)
                StIdle, StDrop: begin
                    if (in_sop) begin
                        start_pkt = 1'b1;
                    end else if (state_q == StDrop && in_eop) begin
                        state_d = StIdle;
                    end
                end
                StPkt: begin
                    if (in_sop) begin
                        // Truncated by a new sop: discard the fragment, then start afresh.
                        base_ptr   = cm_ptr_q;
                        drop_inc   = 2'd1;
                        overflow_d = 1'b1;
                        start_pkt  = 1'b1;
                    end else if (full) begin
                        wr_ptr_d   = cm_ptr_q;
                        drop_inc   = 2'd1;
                        overflow_d = 1'b1;
                        state_d    = in_eop ? StIdle : StDrop;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (in_eop) begin
                            cm_ptr_d = wr_ptr_q + 1'b1;
                            state_d  = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            if (start_pkt) begin
                used_base = base_ptr - rd_ptr_q;
                if (used_base == FULL_LVL) begin
                    wr_ptr_d   = cm_ptr_q;
                    drop_inc   = drop_inc + 2'd1;
                    overflow_d = 1'b1;
                    state_d    = in_eop ? StIdle : StDrop;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = base_ptr[ADDR_WIDTH-1:0];
                    wr_ptr_d  = base_ptr + 1'b1;
                    if (in_eop) begin
                        cm_ptr_d = base_ptr + 1'b1;
                        state_d  = StIdle;
                    end else begin
                        state_d = StPkt;
                    end
                end
            end
        end

        drop_sum     = {1'b0, drop_count_q} + CNT_W'(drop_inc);
        drop_count_d = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
    end

    // Read side: the output register is loaded from the prefetch address so that
    // a transfer is followed by the next word without a bubble.
    always_comb begin
        xfer         = out_valid_q && out_ready;
        rd_ptr_d     = rd_ptr_q + PTR_W'(xfer);
        out_valid_d  = rd_ptr_d != cm_ptr_q;
        out_data_d   = mem_q[rd_ptr_d[ADDR_WIDTH-1:0]];
        fill_level_d = cm_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            cm_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            fill_level_q <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cm_ptr_q     <= cm_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            fill_level_q <= fill_level_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign fill_level = fill_level_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_sonic_vc_rx_fifo_p0_pkt_fifo.sv
// Directed bench for the RX packet FIFO: scoreboard of committed packets plus
// hand-computed checks of pointer, drop and reset behaviour.
module tb_sonic_vc_rx_fifo_p0_pkt_fifo;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic [132:0] in_data;
    logic         out_ready;
    logic         out_valid;
    logic [132:0] out_data;
    logic [4:0]   fill_level;
    logic [15:0]  drop_count;
    logic         overflow;

    int checks = 0;
    int fails  = 0;
    bit rnd_ready = 0;
    int exp_drops = 0;
    logic [132:0] expq [$];

    sonic_vc_rx_fifo_p0_pkt_fifo dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .fill_level (fill_level),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [132:0] mkw(input int p, input bit sop, input bit eop);
        return {3'(p), eop, sop, 128'(p)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every accepted transfer must match the head of the committed-packet queue.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            assert (expq.size() != 0) else begin
                fails++;
                $error("FAIL stream_extra got=%h exp=none", out_data);
            end
            if (expq.size() != 0) begin
                assert (out_data === expq[0]) else begin
                    fails++;
                    $error("FAIL stream got=%h exp=%h", out_data, expq[0]);
                end
                void'(expq.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int p, input bit sop, input bit eop);
        in_valid = 1'b1;
        in_data  = mkw(p, sop, eop);
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic pkt(input int p, input int len);
        for (int i = 0; i < len; i++) begin
            expq.push_back(mkw(p + i, i == 0, i == len - 1));
            send(p + i, i == 0, i == len - 1);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        out_ready = 1'b1;
        while ((expq.size() != 0 || out_valid) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_left"}, 64'(expq.size()), 0);
        chk({tag, "_valid"}, 64'(out_valid), 0);
        chk({tag, "_fill"}, 64'(fill_level), 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_data", out_data[63:0], 0);
        chk("rst_fill", 64'(fill_level), 0);
        chk("rst_drop", 64'(drop_count), 0);
        chk("rst_ovf", 64'(overflow), 0);
        reset_n = 1'b1;
        cyc(1);

        // Single 3-word packet, consumer always ready.
        out_ready = 1'b1;
        pkt(1, 3);
        chk("t1_valid_e0", 64'(out_valid), 0);
        chk("t1_fill_e0", 64'(fill_level), 3);
        cyc(1);
        chk("t1_valid_e1", 64'(out_valid), 1);
        chk("t1_data1", out_data[63:0], 1);
        cyc(1);
        chk("t1_data2", out_data[63:0], 2);
        cyc(1);
        chk("t1_data3", out_data[63:0], 3);
        cyc(1);
        chk("t1_valid_end", 64'(out_valid), 0);
        chk("t1_fill_end", 64'(fill_level), 0);
        chk("t1_drop", 64'(drop_count), 0);

        // Exactly DEPTH words with the consumer stalled.
        out_ready = 1'b0;
        pkt(32'h100, 16);
        cyc(1);
        chk("t2_fill", 64'(fill_level), 16);
        chk("t2_drop", 64'(drop_count), 0);
        chk("t2_valid", 64'(out_valid), 1);
        chk("t2_head", out_data[63:0], 64'h100);
        drain("t2");

        // 10 committed, then a 7-word packet overflows on its last word.
        out_ready = 1'b0;
        pkt(32'h200, 10);
        for (int i = 0; i < 6; i++) send(32'h300 + i, i == 0, 1'b0);
        chk("t3_ovf_pre", 64'(overflow), 0);
        send(32'h306, 1'b0, 1'b1);
        chk("t3_ovf", 64'(overflow), 1);
        chk("t3_drop", 64'(drop_count), 1);
        chk("t3_fill", 64'(fill_level), 10);
        cyc(1);
        chk("t3_ovf_clr", 64'(overflow), 0);
        pkt(32'h400, 2);
        cyc(1);
        chk("t3_fill2", 64'(fill_level), 12);
        drain("t3");

        // Truncation by a second sop; drop count is cumulative (was 1).
        out_ready = 1'b1;
        send(32'h40, 1'b1, 1'b0);
        send(32'h41, 1'b0, 1'b0);
        expq.push_back(mkw(32'h50, 1'b1, 1'b0));
        expq.push_back(mkw(32'h51, 1'b0, 1'b0));
        expq.push_back(mkw(32'h52, 1'b0, 1'b1));
        send(32'h50, 1'b1, 1'b0);
        chk("t4_ovf", 64'(overflow), 1);
        chk("t4_drop", 64'(drop_count), 2);
        send(32'h51, 1'b0, 1'b0);
        chk("t4_ovf_clr", 64'(overflow), 0);
        send(32'h52, 1'b0, 1'b1);
        drain("t4");

        // Orphan words in IDLE are silently discarded.
        send(32'h60, 1'b0, 1'b0);
        send(32'h61, 1'b0, 1'b1);
        cyc(2);
        chk("t5_orph_valid", 64'(out_valid), 0);
        chk("t5_orph_fill", 64'(fill_level), 0);
        chk("t5_orph_drop", 64'(drop_count), 2);

        // 18-word packet: overflow on word 16, DROP swallows word 17.
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) send(32'h700 + i, i == 0, i == 17);
        cyc(1);
        chk("t5_long_drop", 64'(drop_count), 3);
        chk("t5_long_fill", 64'(fill_level), 0);
        chk("t5_long_valid", 64'(out_valid), 0);

        // Random packets with random ready, periodic truncated fragments.
        exp_drops = 3;
        rnd_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int len;
            int n;
            len = int'($urandom_range(1, 5));
            n = 0;
            while (expq.size() + len + 2 > 16 && n < 40) begin
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                n++;
            end
            if (k % 5 == 2) begin
                send(32'h800 + k * 16 + 8, 1'b1, 1'b0);
                send(32'h800 + k * 16 + 9, 1'b0, 1'b0);
                exp_drops++;
            end
            pkt(32'h800 + k * 16, len);
            cyc(int'($urandom_range(0, 2)));
        end
        rnd_ready = 1'b0;
        drain("t5_rand");
        chk("t5_rand_drop", 64'(drop_count), 64'(exp_drops));

        // Reset while a packet is open and a read is in progress.
        out_ready = 1'b0;
        pkt(32'h900, 3);
        send(32'h910, 1'b1, 1'b0);
        send(32'h911, 1'b0, 1'b0);
        chk("t6_valid_pre", 64'(out_valid), 1);
        out_ready = 1'b1;
        cyc(1);
        reset_n = 1'b0;
        expq.delete();
        #1;
        chk("t6_rst_valid", 64'(out_valid), 0);
        chk("t6_rst_fill", 64'(fill_level), 0);
        chk("t6_rst_drop", 64'(drop_count), 0);
        chk("t6_rst_data", out_data[63:0], 0);
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        pkt(32'hA00, 2);
        drain("t6");
        chk("t6_drop", 64'(drop_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
